// File: rtl/bus_reg_slave.sv
// Serial-bus register responder: takes an LSB-first address from the master, then either
// absorbs write data and acks, or serialises the addressed register back over the open-drain bus.
module bus_reg_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_LEN = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_in,
    output logic                  bus_pull,
    input  logic                  rd_wrt,
    input  logic                  bus_util,
    input  logic                  arbiter_cmd_in,
    output logic                  busy_out,
    output logic [DATA_WIDTH-1:0] disp_data,
    output logic                  timeout,
    output logic [3:0]            state
);
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        A_START = 4'd1,
        ADDR    = 4'd2,
        W_START = 4'd3,
        WDATA   = 4'd4,
        ACK     = 4'd5,
        TURN    = 4'd6,
        R_START = 4'd7,
        RDATA   = 4'd8
    } state_t;

    localparam int MAX_W   = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int BIT_W   = $clog2(MAX_W + 1);
    localparam int DWELL_W = (BIT_W > TIMEOUT_LEN) ? BIT_W : TIMEOUT_LEN;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [DWELL_W-1:0]  ADDR_LAST = DWELL_W'(ADDR_WIDTH - 1);
    localparam logic [DWELL_W-1:0]  DATA_LAST = DWELL_W'(DATA_WIDTH - 1);
    localparam logic [DWELL_W-1:0]  TMO_MAX   = DWELL_W'((1 << TIMEOUT_LEN) - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_V   = (ADDR_WIDTH + 1)'(DEPTH);

    state_t cur, nxt;

    // One counter serves as bit index in shift states and as timeout timer in start-wait states;
    // it restarts from zero on every state change.
    logic [DWELL_W-1:0]    dwell;
    logic [ADDR_WIDTH-1:0] addr_sh;
    logic [DATA_WIDTH-1:0] wr_sh;
    logic [DATA_WIDTH-1:0] rd_sh;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic                  abort;
    logic                  wr_en;
    logic                  tmo_hit;
    logic                  pull_nxt;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [IDX_W-1:0]      idx;

    assign in_range = ({1'b0, addr_sh} < DEPTH_V);
    assign idx      = addr_sh[IDX_W-1:0];
    assign wr_word  = {bus_in, wr_sh[DATA_WIDTH-1:1]};
    assign state    = cur;
    assign busy_out = (cur != IDLE);

    always_comb begin
        nxt      = cur;
        wr_en    = 1'b0;
        tmo_hit  = 1'b0;
        pull_nxt = 1'b0;
        abort    = bus_util && (cur != IDLE) && (cur != A_START);
        case (cur)
            IDLE:    if (arbiter_cmd_in) nxt = A_START;
            A_START: begin
                if (!bus_in) begin
                    nxt = ADDR;
                end else if (dwell == TMO_MAX) begin
                    nxt     = IDLE;
                    tmo_hit = 1'b1;
                end
            end
            ADDR:    if (dwell == ADDR_LAST) nxt = rd_wrt ? W_START : TURN;
            W_START: begin
                if (!bus_in) begin
                    nxt = WDATA;
                end else if (dwell == TMO_MAX) begin
                    nxt     = IDLE;
                    tmo_hit = 1'b1;
                end
            end
            WDATA: begin
                if (dwell == DATA_LAST) begin
                    nxt   = ACK;
                    wr_en = in_range;
                end
            end
            ACK:     nxt = IDLE;
            TURN:    nxt = R_START;
            R_START: nxt = RDATA;
            RDATA:   if (dwell == DATA_LAST) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort) begin
            nxt     = IDLE;
            wr_en   = 1'b0;
            tmo_hit = 1'b0;
        end
        // bus_pull is registered, so it is decided from the state being entered
        case (nxt)
            ACK, R_START: pull_nxt = 1'b1;
            RDATA:        pull_nxt = ~rd_sh[0];
            default:      pull_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= IDLE;
            bus_pull  <= 1'b0;
            timeout   <= 1'b0;
            disp_data <= '0;
            dwell     <= '0;
        end else begin
            cur      <= nxt;
            bus_pull <= pull_nxt;
            timeout  <= tmo_hit;
            dwell    <= (nxt != cur) ? '0 : dwell + 1'b1;
            if (wr_en) disp_data <= wr_word;
        end
    end

    // Datapath: shift registers and the bank are never reset; the bank only changes on a completed write
    always_ff @(posedge clk) begin
        if (cur == ADDR) addr_sh <= {bus_in, addr_sh[ADDR_WIDTH-1:1]};
        if (cur == WDATA) wr_sh <= wr_word;
        if (cur == TURN) begin
            rd_sh <= in_range ? mem[idx] : '0;
        end else if (cur == R_START || cur == RDATA) begin
            rd_sh <= rd_sh >> 1;
        end
        if (wr_en && !rst) mem[idx] <= wr_word;
    end
endmodule
